// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider plus horizontal/vertical raster counters
// for a 640x480@60 frame (800x525 total). Produces registered hSync/vSync/bright
// aligned with hCount/vCount, a one-cycle frame_tick, and a slow game_clk.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frames-since-reset counter;
// without it frame_count is tied to zero.
module vga_timing_gen #(
  parameter int PIX_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_START  = 144,
  parameter int H_END    = 783,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_START  = 35,
  parameter int V_END    = 514,
  parameter int GAME_DIV = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        game_clk,
  output logic [15:0] frame_count
);

  localparam int DW = $clog2(PIX_DIV);
  localparam int GW = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_d, v_d;
  logic          step, h_wrap, v_wrap;
  logic [GW-1:0] game_q, game_d;
  logic          game_clk_d;

  // Next-state for divider, raster counters and game-clock divider.
  // Sync/bright are decoded from these next values so they land on the
  // same edge as the counters they describe.
  always_comb begin
    div_d      = (div_q >= DW'(PIX_DIV - 1)) ? '0 : div_q + 1'b1;
    step       = (div_q == DW'(PIX_DIV - 1));
    h_wrap     = (hCount >= 10'(H_TOTAL - 1));
    v_wrap     = (vCount >= 10'(V_TOTAL - 1));
    h_d        = hCount;
    v_d        = vCount;
    game_d     = game_q;
    game_clk_d = game_clk;
    if (step) begin
      h_d = h_wrap ? '0 : hCount + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : vCount + 10'd1;
      end
    end
    if (frame_tick) begin
      if (game_q == GW'(GAME_DIV - 1)) begin
        game_d     = '0;
        game_clk_d = ~game_clk;
      end else begin
        game_d = game_q + 1'b1;
      end
    end
  end

  // Register all timing state and decoded outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q      <= '0;
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      pix_en     <= 1'b0;
      frame_tick <= 1'b0;
      game_q     <= '0;
      game_clk   <= 1'b0;
    end else begin
      div_q      <= div_d;
      hCount     <= h_d;
      vCount     <= v_d;
      hSync      <= (h_d >= 10'(H_SYNC));
      vSync      <= (v_d >= 10'(V_SYNC));
      bright     <= (h_d >= 10'(H_START)) && (h_d <= 10'(H_END)) &&
                    (v_d >= 10'(V_START)) && (v_d <= 10'(V_END));
      pix_en     <= (div_d == DW'(PIX_DIV - 1));
      frame_tick <= step && h_wrap && v_wrap;
      game_q     <= game_d;
      game_clk   <= game_clk_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Count completed frames; wraps naturally at 16 bits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_count <= '0;
    end else if (frame_tick) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule
